// File: rtl/any1_issue_sched.sv
// any1_issue_sched: multi-channel registered issue scheduler for the ANY-1 core.
// Wakes ROB entries whose operands and ordering constraints are satisfied, then
// picks up to NCH of them per cycle (starved first, then branches, then oldest)
// and holds each pick on a valid/ready issue port until the functional unit takes it.
// Entries that are issued but not yet reported out are tracked in pend_q.
module any1_issue_sched #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned IDXW    = 6,
  parameter int unsigned NCH     = 2,
  parameter int unsigned AGE_MAX = 15
) (
  input  logic                    rst_i,
  input  logic                    clk_i,
  input  logic                    flush_i,
  input  logic [IDXW-1:0]         rob_que_i,
  input  logic [ENTRIES-1:0]      ent_v_i,
  input  logic [ENTRIES-1:0]      ent_dec_i,
  input  logic [ENTRIES-1:0]      ent_cmt_i,
  input  logic [ENTRIES-1:0]      ent_out_i,
  input  logic [ENTRIES-1:0]      ent_argv_i,
  input  logic [ENTRIES-1:0]      ent_mem_i,
  input  logic [ENTRIES-1:0]      ent_br_i,
  input  logic [ENTRIES-1:0]      ent_fc_i,
  input  logic [NCH*ENTRIES-1:0]  ch_ok_i,
  input  logic [NCH-1:0]          fu_rdy_i,
  output logic [NCH-1:0]          iss_v_o,
  output logic [NCH*IDXW-1:0]     iss_id_o,
  output logic [ENTRIES-1:0]      wakeup_o,
  output logic                    starve_o
);

  logic [NCH-1:0]      iss_v_q, iss_v_d;
  logic [NCH*IDXW-1:0] iss_id_q, iss_id_d;
  logic [ENTRIES-1:0]  wakeup_q;
  logic                starve_q, starve_d;
  logic [ENTRIES-1:0]  pend_q, pend_d;
  logic [7:0]          age_q [ENTRIES];
  logic [7:0]          age_d [ENTRIES];
  logic [ENTRIES-1:0]  wake;
  logic [ENTRIES-1:0]  starved;
  logic [ENTRIES-1:0]  sel_mask;

  assign iss_v_o  = iss_v_q;
  assign iss_id_o = iss_id_q;
  assign wakeup_o = wakeup_q;
  assign starve_o = starve_q;

  // Returns {found, index} of the first set bit walking upward from que (oldest first).
  function automatic logic [IDXW:0] pick_oldest(input logic [ENTRIES-1:0] vec,
                                                input logic [IDXW-1:0]    que);
    logic [IDXW:0]   res;
    logic [IDXW-1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      idx = que + IDXW'(i);
      if (vec[idx] && !res[IDXW]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Wakeup: walk in age order, accumulating older fences and older unfinished mem ops.
  always_comb begin
    logic            fc_seen;
    logic            mem_seen;
    logic [IDXW-1:0] idx;
    fc_seen  = 1'b0;
    mem_seen = 1'b0;
    idx      = '0;
    wake     = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      idx = rob_que_i + IDXW'(i);
      if (ent_v_i[idx] && ent_dec_i[idx] && !ent_cmt_i[idx] && !ent_out_i[idx] &&
          ent_argv_i[idx] && !pend_q[idx] && !fc_seen && !(ent_mem_i[idx] && mem_seen)) begin
        wake[idx] = 1'b1;
      end
      if (ent_v_i[idx] && ent_fc_i[idx] && !ent_cmt_i[idx]) fc_seen = 1'b1;
      // Pending mem ops are still not out, so they keep blocking younger mem ops.
      if (ent_v_i[idx] && ent_mem_i[idx] && !ent_cmt_i[idx] && !ent_out_i[idx]) mem_seen = 1'b1;
    end
  end

  // Entries that have waited AGE_MAX cycles since wakeup.
  always_comb begin
    starved = '0;
    for (int unsigned n = 0; n < ENTRIES; n++) begin
      starved[n] = (age_q[n] == 8'(AGE_MAX));
    end
  end

  // Selection over free channels in ascending order; busy channels hold their entry.
  always_comb begin
    logic [ENTRIES-1:0] cand;
    logic [ENTRIES-1:0] chosen;
    logic               mem_taken;
    logic [IDXW:0]      pick_s, pick_b, pick_o;
    logic [IDXW-1:0]    pick_id;
    logic               found;
    cand      = '0;
    chosen    = '0;
    mem_taken = 1'b0;
    pick_s    = '0;
    pick_b    = '0;
    pick_o    = '0;
    pick_id   = '0;
    found     = 1'b0;
    iss_v_d   = iss_v_q;
    iss_id_d  = iss_id_q;
    starve_d  = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (!iss_v_q[c] || fu_rdy_i[c]) begin
        cand = wake & ch_ok_i[c*ENTRIES +: ENTRIES] & ~chosen;
        if (mem_taken) cand = cand & ~ent_mem_i;
        pick_s  = pick_oldest(cand & starved, rob_que_i);
        pick_b  = pick_oldest(cand & ent_br_i, rob_que_i);
        pick_o  = pick_oldest(cand, rob_que_i);
        found   = 1'b1;
        pick_id = '1;
        if (pick_s[IDXW]) begin
          pick_id  = pick_s[IDXW-1:0];
          starve_d = 1'b1;
        end else if (pick_b[IDXW]) begin
          pick_id = pick_b[IDXW-1:0];
        end else if (pick_o[IDXW]) begin
          pick_id = pick_o[IDXW-1:0];
        end else begin
          found = 1'b0;
        end
        iss_v_d[c]                 = found;
        iss_id_d[c*IDXW +: IDXW]   = pick_id;
        if (found) begin
          chosen[pick_id] = 1'b1;
          if (ent_mem_i[pick_id]) mem_taken = 1'b1;
        end
      end
    end
    if (flush_i) begin
      iss_v_d  = '0;
      iss_id_d = '1;
      starve_d = 1'b0;
      chosen   = '0;
    end
    sel_mask = chosen;
  end

  // Pending tracking and age counters.
  always_comb begin
    pend_d = (pend_q & ent_v_i & ~ent_out_i) | sel_mask;
    if (flush_i) pend_d = '0;
    for (int unsigned n = 0; n < ENTRIES; n++) begin
      if (flush_i || !wake[n] || sel_mask[n]) begin
        age_d[n] = '0;
      end else if (age_q[n] < 8'(AGE_MAX)) begin
        age_d[n] = age_q[n] + 8'd1;
      end else begin
        age_d[n] = age_q[n];
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iss_v_q  <= '0;
      iss_id_q <= '1;
      wakeup_q <= '0;
      starve_q <= 1'b0;
      pend_q   <= '0;
      for (int unsigned n = 0; n < ENTRIES; n++) age_q[n] <= '0;
    end else begin
      iss_v_q  <= iss_v_d;
      iss_id_q <= iss_id_d;
      wakeup_q <= flush_i ? '0 : wake;
      starve_q <= starve_d;
      pend_q   <= pend_d;
      for (int unsigned n = 0; n < ENTRIES; n++) age_q[n] <= age_d[n];
    end
  end

endmodule

// File: tb/tb_any1_issue_sched.sv
// Bench for any1_issue_sched with ENTRIES=8, NCH=2, AGE_MAX=3.
// Each vector drives one cycle of inputs; its expected post-edge outputs are queued
// and popped for comparison one time unit after the edge.
module tb_any1_issue_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  que;
  logic [7:0]  v, dec, cmt, out, argv, mem, br, fc;
  logic [15:0] ch_ok;
  logic [1:0]  fu_rdy;
  logic [1:0]  iss_v;
  logic [5:0]  iss_id;
  logic [7:0]  wakeup;
  logic        starve;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        r;
    logic        fl;
    logic [2:0]  q;
    logic [7:0]  v, dec, cmt, out, argv, mem, br, fc;
    logic [15:0] ok;
    logic [1:0]  fu;
    logic [1:0]  ev;
    logic [5:0]  eid;
    logic [7:0]  ew;
    logic        es;
  } vec_t;

  typedef logic [16:0] exp_t;  // {iss_v, iss_id, wakeup, starve}
  exp_t exp_q[$];
  vec_t tab[$];

  any1_issue_sched #(
    .ENTRIES(8),
    .IDXW   (3),
    .NCH    (2),
    .AGE_MAX(3)
  ) dut (
    .rst_i     (rst),
    .clk_i     (clk),
    .flush_i   (flush),
    .rob_que_i (que),
    .ent_v_i   (v),
    .ent_dec_i (dec),
    .ent_cmt_i (cmt),
    .ent_out_i (out),
    .ent_argv_i(argv),
    .ent_mem_i (mem),
    .ent_br_i  (br),
    .ent_fc_i  (fc),
    .ch_ok_i   (ch_ok),
    .fu_rdy_i  (fu_rdy),
    .iss_v_o   (iss_v),
    .iss_id_o  (iss_id),
    .wakeup_o  (wakeup),
    .starve_o  (starve)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic r, input logic fl, input logic [2:0] q,
                              input logic [7:0] vv, dd, cc, oo, aa, mm, bb, ff,
                              input logic [15:0] ok, input logic [1:0] fu,
                              input logic [1:0] ev, input logic [5:0] eid,
                              input logic [7:0] ew, input logic es);
    vec_t t;
    t.r = r; t.fl = fl; t.q = q;
    t.v = vv; t.dec = dd; t.cmt = cc; t.out = oo; t.argv = aa;
    t.mem = mm; t.br = bb; t.fc = ff; t.ok = ok; t.fu = fu;
    t.ev = ev; t.eid = eid; t.ew = ew; t.es = es;
    return t;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got v=%b id=%h wake=%h starve=%b, want v=%b id=%h wake=%h starve=%b",
               name, got[16:15], got[14:9], got[8:1], got[0],
               want[16:15], want[14:9], want[8:1], want[0]);
    end
  endtask

  task automatic zero_inputs();
    flush = 0; que = 0; v = 0; dec = 0; cmt = 0; out = 0; argv = 0;
    mem = 0; br = 0; fc = 0; ch_ok = 0; fu_rdy = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    zero_inputs();
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic check_sb(input string name);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got no queued expectation, want one", name);
    end else begin
      check(name, {iss_v, iss_id, wakeup, starve}, exp_q.pop_front());
    end
  endtask

  task automatic drive(input string name, input vec_t t);
    if (t.r) do_reset();
    flush = t.fl; que = t.q; v = t.v; dec = t.dec; cmt = t.cmt; out = t.out;
    argv = t.argv; mem = t.mem; br = t.br; fc = t.fc; ch_ok = t.ok; fu_rdy = t.fu;
    exp_q.push_back({t.ev, t.eid, t.ew, t.es});
    @(posedge clk);
    #1 check_sb(name);
  endtask

  initial begin
    rst = 0;
    zero_inputs();
    #2 rst = 1;
    #1 check("reset_state", {iss_v, iss_id, wakeup, starve}, {2'b00, 6'h3F, 8'h00, 1'b0});

    // Age order with wrap: que=6, ready 1,5,7.
    tab.push_back(mk(1, 0, 6, 8'hA2, 8'hA2, 0, 0, 8'hA2, 0, 0, 0, 16'hFFFF, 3, 2'b11, 6'h0F, 8'hA2, 0));
    tab.push_back(mk(0, 0, 6, 8'hA2, 8'hA2, 0, 0, 8'hA2, 0, 0, 0, 16'hFFFF, 3, 2'b01, 6'h3D, 8'h20, 0));
    tab.push_back(mk(0, 0, 6, 8'hA2, 8'hA2, 0, 0, 8'hA2, 0, 0, 0, 16'hFFFF, 3, 2'b00, 6'h3F, 8'h00, 0));
    tab.push_back(mk(0, 0, 6, 8'hA2, 8'hA2, 0, 8'hA2, 8'hA2, 0, 0, 0, 16'hFFFF, 3, 2'b00, 6'h3F, 8'h00, 0));
    tab.push_back(mk(0, 0, 6, 8'hA2, 8'hA2, 0, 0, 8'hA2, 0, 0, 0, 16'hFFFF, 3, 2'b11, 6'h0F, 8'hA2, 0));
    // Branch priority; entry 3 is valid but not decoded.
    tab.push_back(mk(1, 0, 0, 8'h1C, 8'h14, 0, 0, 8'h1C, 0, 8'h10, 0, 16'hFFFF, 3, 2'b11, 6'h14, 8'h14, 0));
    // Memory ordering.
    tab.push_back(mk(1, 0, 0, 8'h0A, 8'h0A, 0, 0, 8'h0A, 8'h0A, 0, 0, 16'hFFFF, 3, 2'b01, 6'h39, 8'h02, 0));
    tab.push_back(mk(0, 0, 0, 8'h0A, 8'h0A, 0, 0, 8'h0A, 8'h0A, 0, 0, 16'hFFFF, 3, 2'b00, 6'h3F, 8'h00, 0));
    tab.push_back(mk(0, 0, 0, 8'h0A, 8'h0A, 0, 8'h02, 8'h0A, 8'h0A, 0, 0, 16'hFFFF, 3, 2'b01, 6'h3B, 8'h08, 0));
    // Flow-control fence at 2 (out, not committed) blocks 5 until commit.
    tab.push_back(mk(1, 0, 0, 8'h24, 8'h24, 0, 8'h04, 8'h24, 0, 0, 8'h04, 16'hFFFF, 3, 2'b00, 6'h3F, 8'h00, 0));
    tab.push_back(mk(0, 0, 0, 8'h24, 8'h24, 0, 8'h04, 8'h24, 0, 0, 8'h04, 16'hFFFF, 3, 2'b00, 6'h3F, 8'h00, 0));
    tab.push_back(mk(0, 0, 0, 8'h24, 8'h24, 8'h04, 8'h04, 8'h24, 0, 0, 8'h04, 16'hFFFF, 3, 2'b01, 6'h3D, 8'h20, 0));
    // Channel capability: entry 0 only runs on channel 1.
    tab.push_back(mk(1, 0, 0, 8'h01, 8'h01, 0, 0, 8'h01, 0, 0, 0, 16'h0100, 3, 2'b10, 6'h07, 8'h01, 0));

    for (int i = 0; i < tab.size(); i++) drive($sformatf("vec[%0d]", i), tab[i]);

    // Stall: channel 0 holds entry 3 while the unit is not ready.
    drive("stall_load", mk(1, 0, 0, 8'h08, 8'h08, 0, 0, 8'h08, 0, 0, 0, 16'hFFFF, 0, 2'b01, 6'h3B, 8'h08, 0));
    for (int i = 0; i < 5; i++)
      drive($sformatf("stall_hold[%0d]", i),
            mk(0, 0, 0, 8'h08, 8'h08, 0, 0, 8'h08, 0, 0, 0, 16'hFFFF, 0, 2'b01, 6'h3B, 8'h00, 0));
    drive("stall_release", mk(0, 0, 0, 8'h08, 8'h08, 0, 0, 8'h08, 0, 0, 0, 16'hFFFF, 1, 2'b00, 6'h3F, 8'h00, 0));

    // Starvation: entry 6 loses to younger branches until its age reaches 3.
    drive("starve_1", mk(1, 0, 4, 8'hC0, 8'hC0, 0, 0, 8'hC0, 0, 8'h80, 0, 16'h00FF, 1, 2'b01, 6'h3F, 8'hC0, 0));
    drive("starve_2", mk(0, 0, 4, 8'hC1, 8'hC1, 0, 8'h80, 8'hC1, 0, 8'h81, 0, 16'h00FF, 1, 2'b01, 6'h38, 8'h41, 0));
    drive("starve_3", mk(0, 0, 4, 8'hC3, 8'hC3, 0, 8'h81, 8'hC3, 0, 8'h83, 0, 16'h00FF, 1, 2'b01, 6'h39, 8'h42, 0));
    drive("starve_4", mk(0, 0, 4, 8'hC7, 8'hC7, 0, 8'h83, 8'hC7, 0, 8'h87, 0, 16'h00FF, 1, 2'b01, 6'h3E, 8'h44, 1));
    drive("starve_5", mk(0, 0, 4, 8'hC7, 8'hC7, 0, 8'h83, 8'hC7, 0, 8'h87, 0, 16'h00FF, 1, 2'b01, 6'h3A, 8'h04, 0));

    // Flush with both channels stalled, then reissue of the same entries.
    drive("flush_load", mk(1, 0, 0, 8'h06, 8'h06, 0, 0, 8'h06, 0, 0, 0, 16'hFFFF, 0, 2'b11, 6'h11, 8'h06, 0));
    drive("flush_hold", mk(0, 0, 0, 8'h06, 8'h06, 0, 0, 8'h06, 0, 0, 0, 16'hFFFF, 0, 2'b11, 6'h11, 8'h00, 0));
    drive("flush_pulse", mk(0, 1, 0, 8'h06, 8'h06, 0, 0, 8'h06, 0, 0, 0, 16'hFFFF, 0, 2'b00, 6'h3F, 8'h00, 0));
    drive("flush_reissue", mk(0, 0, 0, 8'h06, 8'h06, 0, 0, 8'h06, 0, 0, 0, 16'hFFFF, 3, 2'b11, 6'h11, 8'h06, 0));

    // Asynchronous reset in the middle of traffic, then first issue after release.
    #2 rst = 1;
    #1 check("async_reset", {iss_v, iss_id, wakeup, starve}, {2'b00, 6'h3F, 8'h00, 1'b0});
    @(posedge clk);
    #1 rst = 0;
    drive("post_reset", mk(0, 0, 0, 8'h06, 8'h06, 0, 0, 8'h06, 0, 0, 0, 16'hFFFF, 3, 2'b11, 6'h11, 8'h06, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
